// File: rtl/codec_slave.sv
// Codec-side endpoint of the serial audio link: deserializes DAC words from SDin,
// serializes ADC words onto SDout, all timed from link clock edges sampled on clk.
module codec_slave #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    RSTn,
    input  logic                    LRCLK,
    input  logic                    SCLK,
    input  logic                    MCLK,
    input  logic                    SDin,
    output logic                    SDout,
    input  logic signed [WIDTH-1:0] adc_lft,
    input  logic signed [WIDTH-1:0] adc_rht,
    output logic                    adc_req,
    output logic signed [WIDTH-1:0] dac_lft,
    output logic signed [WIDTH-1:0] dac_rht,
    output logic                    dac_valid,
    output logic                    frame_err,
    output logic                    mclk_ok
);

    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        RUN
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic              lr_q;
    logic              sclk_q;
    logic              mclk_q;
    logic              lr_rise;
    logic              lr_fall;
    logic              sclk_rise;
    logic              sclk_fall;

    logic [WIDTH-1:0]  rx_shift_reg;
    logic [WIDTH-1:0]  tx_shift_reg;
    logic [WIDTH-1:0]  rht_hold_reg;
    logic [CW-1:0]     bit_cnt_reg;
    logic [2:0]        mclk_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lr_q   <= 1'b0;
            sclk_q <= 1'b0;
            mclk_q <= 1'b0;
        end else begin
            lr_q   <= LRCLK;
            sclk_q <= SCLK;
            mclk_q <= MCLK;
        end
    end

    assign lr_rise   =  LRCLK & ~lr_q;
    assign lr_fall   = ~LRCLK &  lr_q;
    assign sclk_rise =  SCLK  & ~sclk_q;
    assign sclk_fall = ~SCLK  &  sclk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = SYNC;
            SYNC:    if (lr_rise) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
        if (!RSTn) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift_reg <= '0;
            tx_shift_reg <= '0;
            rht_hold_reg <= '0;
            bit_cnt_reg  <= '0;
            dac_lft      <= '0;
            dac_rht      <= '0;
            dac_valid    <= 1'b0;
            adc_req      <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            dac_valid <= 1'b0;
            adc_req   <= 1'b0;
            if (!RSTn || state_reg == IDLE) begin
                rx_shift_reg <= '0;
                tx_shift_reg <= '0;
                rht_hold_reg <= '0;
                bit_cnt_reg  <= '0;
                if (!RSTn) begin
                    frame_err <= 1'b0;
                end
            end else if (state_reg == SYNC) begin
                // First frame boundary: only the transmit side is primed; the partial frame is discarded.
                if (lr_rise) begin
                    tx_shift_reg <= adc_lft;
                    rht_hold_reg <= adc_rht;
                    adc_req      <= 1'b1;
                    bit_cnt_reg  <= '0;
                end
            end else begin
                if (lr_rise || lr_fall) begin
                    // LRCLK edge wins over a coincident SCLK edge; rx latch uses the pre-edge shifter.
                    if (bit_cnt_reg != CW'(WIDTH)) begin
                        frame_err <= 1'b1;
                    end
                    bit_cnt_reg <= '0;
                    if (lr_rise) begin
                        dac_rht      <= rx_shift_reg;
                        dac_valid    <= 1'b1;
                        tx_shift_reg <= adc_lft;
                        rht_hold_reg <= adc_rht;
                        adc_req      <= 1'b1;
                    end else begin
                        dac_lft      <= rx_shift_reg;
                        tx_shift_reg <= rht_hold_reg;
                    end
                end else begin
                    if (sclk_rise) begin
                        rx_shift_reg <= {rx_shift_reg[WIDTH-2:0], SDin};
                        if (bit_cnt_reg != CW'(WIDTH + 1)) begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                    if (sclk_fall) begin
                        tx_shift_reg <= {tx_shift_reg[WIDTH-2:0], 1'b0};
                    end
                end
            end
        end
    end

    // Counter rests at 7 out of reset so mclk_ok starts low until MCLK is seen moving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mclk_cnt_reg <= 3'd7;
        end else if (MCLK != mclk_q) begin
            mclk_cnt_reg <= 3'd0;
        end else if (mclk_cnt_reg != 3'd7) begin
            mclk_cnt_reg <= mclk_cnt_reg + 3'd1;
        end
    end

    assign mclk_ok = (mclk_cnt_reg != 3'd7) && RSTn;
    assign SDout   = tx_shift_reg[WIDTH-1];

endmodule

// File: doc/codec_slave.md
Name: codec_slave

Overview:
- Synthesizable model of the CODEC end of the serial audio link.
- It sits on the far side of the codec interface. It takes LRCLK/SCLK/MCLK/RSTn/SDin from the master and drives SDout.
- Received DAC words are deserialized into a left/right pair. ADC words are serialized back onto SDout.
- Used in system simulation and in FPGA loopback builds. Everything runs on the system clock, with edges detected from sampled link clocks.

Parameters:
- WIDTH, 16, bits per channel word. It is also the number of SCLK periods per LRCLK phase.

Ports:
- clk  input  1  system clock (50 MHz)
- rst_n  input  1  asynchronous active-low reset
- RSTn  input  1  codec reset from master; low holds the block idle
- LRCLK  input  1  frame clock; high = left phase, low = right phase
- SCLK  input  1  bit clock
- MCLK  input  1  master clock; monitored only
- SDin  input  1  serial DAC data from master, MSB first
- SDout  output  1  serial ADC data to master, MSB first
- adc_lft  input  WIDTH  signed left ADC sample to transmit
- adc_rht  input  WIDTH  signed right ADC sample to transmit
- adc_req  output  1  one-cycle pulse; adc_lft/adc_rht were just captured and the source may advance
- dac_lft  output  WIDTH  last received left word
- dac_rht  output  WIDTH  last received right word
- dac_valid  output  1  one-cycle pulse; a new dac_lft/dac_rht pair was just written
- frame_err  output  1  sticky; a phase had a bit count other than WIDTH; cleared only by rst_n or RSTn low
- mclk_ok  output  1  high once an MCLK toggle has been seen within the last 8 clk

Behaviour:
- Input sampling:
  - LRCLK, SCLK and MCLK are each registered once (_q).
  - Edges are derived from current vs _q: lr_rise, lr_fall, sclk_rise, sclk_fall.
  - All actions occur in the clk cycle in which an edge is detected.
- Reset: rst_n low sets all outputs to 0 (SDout=0, dac_*=0, pulses=0, frame_err=0, mclk_ok=0), shift registers and bit counter to 0, and the FSM to IDLE.
- FSM states:
  - IDLE: entered on reset or whenever RSTn==0, from any state. SDout held 0 and shifters cleared. Go to SYNC when RSTn==1.
  - SYNC: ignore data and wait for the first lr_rise. At lr_rise, perform the left-phase load (below), clear the bit counter, then go to RUN. No dac_valid is raised for the partial frame.
  - RUN: normal operation.
- Receive (RUN):
  - On sclk_rise: rx_shift <= {rx_shift[WIDTH-2:0], SDin} and bitcnt++.
  - bitcnt saturates at WIDTH+1 and does not wrap.
  - On lr_fall: dac_lft <= rx_shift.
  - On lr_rise: dac_rht <= rx_shift and dac_valid=1 for that cycle. This is the only cycle dac_valid is high.
  - At any LRCLK edge, if bitcnt != WIDTH then frame_err <= 1, but the words are still latched.
  - bitcnt clears to 0 at every LRCLK edge.
- Transmit (RUN, plus the SYNC→RUN transition):
  - On lr_rise: tx_shift <= adc_lft, rht_hold <= adc_rht, adc_req=1 for that cycle.
  - On lr_fall: tx_shift <= rht_hold. The pair stays coherent even if the source changes mid-frame.
  - On sclk_fall with no LRCLK edge in the same cycle: tx_shift <= {tx_shift[WIDTH-2:0], 1'b0}.
  - The LRCLK edge has priority over a coincident sclk_fall, since the master drops SCLK at the LRCLK edge.
  - SDout = tx_shift[WIDTH-1], so the MSB is valid one clk after the LRCLK edge, well before the master's first SCLK rise 16 clk later.
- mclk_ok: a 3-bit counter cleared on any MCLK toggle and incremented otherwise, saturating at 7. mclk_ok = (counter != 7) and RSTn.
- RSTn falling mid-frame: immediate IDLE. No partial-word dac_valid. A new SYNC is required after RSTn returns high.
- Simultaneous events: at an LRCLK edge, the rx latch uses rx_shift from before any sclk_rise in the same cycle. A coincident sclk_rise cannot legally occur; if it does, it is ignored.

Test Plan:
- Reset then RSTn high: SDout=0, no dac_valid until the first lr_rise. The partial first frame produces no dac_valid and no frame_err.
- Master sends left=16'h8001, right=16'h7FFE -> dac_lft=8001 at lr_fall, dac_rht=7FFE and a single-cycle dac_valid at lr_rise, frame_err stays 0.
- adc_lft=16'hA5C3, adc_rht=16'h0F0F held -> master-side deserializer reads A5C3 then 0F0F. adc_req pulses exactly once per frame, coincident with lr_rise.
- Change adc_rht to 16'h1234 during the left phase after adc_req -> transmitted right word is still the value captured at lr_rise; 1234 appears in the next frame.
- Inject a phase with 15 SCLK rises -> frame_err=1 and stays set across later good frames; RSTn low clears it.
- Drop RSTn mid-left-phase for 40 clk -> SDout=0, no dac_valid. After RSTn returns, the first valid pair arrives only after a full SYNC frame. Stop MCLK for 10 clk -> mclk_ok falls.
